// File: rtl/color_seq_fader.sv
// color_seq_fader: steps an RGB palette (OFF, then 0..6 with wrap) and drives
// three registered PWM outputs from the palette duty values.
// Modes: AUTO steps on a dwell timer, HOLD freezes everything, MANUAL steps
// on rising edges of 'step', and FADE steps like AUTO while ramping the duty
// values one LSB per prescaler tick.
// Build option: define COLOR_SEQ_FADE_EN to compile in FADE mode and its
// prescaler; without it sw=10 behaves exactly as AUTO.
//
// Colour sequencer states:
//   state    | meaning
//   C_RED    | palette 0 (255,0,0)
//   C_ORANGE | palette 1 (255,97,0)
//   C_YELLOW | palette 2 (255,255,0)
//   C_GREEN  | palette 3 (0,255,0)
//   C_BLUE   | palette 4 (0,0,255)
//   C_NAVY   | palette 5 (8,46,84)
//   C_PURPLE | palette 6 (160,32,240), next advance wraps to C_RED
//   C_OFF    | (0,0,0), entered only by reset, next advance goes to C_RED
module color_seq_fader #(
  parameter int DUTY_W       = 8,
  parameter int DWELL_CYCLES = 62500000,
  parameter int FADE_DIV     = 245000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        sw,
  input  logic              step,
  output logic [2:0]        color_idx,
  output logic [DUTY_W-1:0] r_duty,
  output logic [DUTY_W-1:0] g_duty,
  output logic [DUTY_W-1:0] b_duty,
  output logic              pwm_r,
  output logic              pwm_g,
  output logic              pwm_b
);

  // Elaboration-time parameter range checks.
  if (DUTY_W < 8 || DUTY_W > 12) begin : g_bad_duty_w
    $error("color_seq_fader: DUTY_W must be 8..12");
  end
  if (DWELL_CYCLES < 2) begin : g_bad_dwell
    $error("color_seq_fader: DWELL_CYCLES must be >= 2");
  end
  if (FADE_DIV < 1) begin : g_bad_fade_div
    $error("color_seq_fader: FADE_DIV must be >= 1");
  end

  localparam int DWELL_W = $clog2(DWELL_CYCLES);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [DUTY_W-1:0]  PWM_LAST   = DUTY_W'((1 << DUTY_W) - 2);

  typedef enum logic [2:0] {
    C_RED    = 3'd0,
    C_ORANGE = 3'd1,
    C_YELLOW = 3'd2,
    C_GREEN  = 3'd3,
    C_BLUE   = 3'd4,
    C_NAVY   = 3'd5,
    C_PURPLE = 3'd6,
    C_OFF    = 3'd7
  } color_t;

  typedef enum logic [1:0] {
    M_AUTO   = 2'b00,
    M_HOLD   = 2'b01,
    M_FADE   = 2'b10,
    M_MANUAL = 2'b11
  } mode_t;

  function automatic logic [23:0] palette(input color_t c);
    case (c)
      C_RED:    palette = {8'd255, 8'd0,   8'd0};
      C_ORANGE: palette = {8'd255, 8'd97,  8'd0};
      C_YELLOW: palette = {8'd255, 8'd255, 8'd0};
      C_GREEN:  palette = {8'd0,   8'd255, 8'd0};
      C_BLUE:   palette = {8'd0,   8'd0,   8'd255};
      C_NAVY:   palette = {8'd8,   8'd46,  8'd84};
      C_PURPLE: palette = {8'd160, 8'd32,  8'd240};
      default:  palette = 24'd0;
    endcase
  endfunction

  // Top-bit replication: the top DUTY_W bits of {v,v} keep 255 at all-ones.
  function automatic logic [DUTY_W-1:0] scale(input logic [7:0] v);
    logic [15:0] rep;
    rep = {v, v};
    return rep[15 -: DUTY_W];
  endfunction

  color_t            color_q, color_d;
  mode_t             mode_eff;
  logic [1:0]        sw_q;
  logic              step_q;
  logic              sw_chg, step_rise, advance;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DUTY_W-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic [DUTY_W-1:0] pwm_cnt;
  logic [23:0]       pal_next;

  assign sw_chg    = (sw != sw_q);
  assign step_rise = step & ~step_q;
  assign pal_next  = palette(color_d);

  // Map the mode switch to the effective mode (FADE folds into AUTO when absent).
  always_comb begin
    mode_eff = mode_t'(sw);
`ifndef COLOR_SEQ_FADE_EN
    if (mode_eff == M_FADE) mode_eff = M_AUTO;
`endif
  end

`ifdef COLOR_SEQ_FADE_EN
  localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_DIV - 1);

  logic [FADE_W-1:0] fade_cnt;
  logic              fade_tc;
  logic [23:0]       pal_cur;

  assign fade_tc = (fade_cnt == FADE_LAST);
  assign pal_cur = palette(color_q);

  function automatic logic [DUTY_W-1:0] toward(input logic [DUTY_W-1:0] cur,
                                               input logic [DUTY_W-1:0] tgt);
    if (cur < tgt)      return cur + 1'b1;
    else if (cur > tgt) return cur - 1'b1;
    else                return cur;
  endfunction

  // Fade prescaler: runs only in FADE, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (rst)                    fade_cnt <= '0;
    else if (mode_eff != M_FADE) fade_cnt <= '0;
    else if (fade_tc)           fade_cnt <= '0;
    else                        fade_cnt <= fade_cnt + 1'b1;
  end
`endif

  // Sequencer state register plus mode/step history.
  always_ff @(posedge clk) begin
    if (rst) begin
      color_q <= C_OFF;
      dwell_q <= '0;
      step_q  <= 1'b0;
      sw_q    <= sw;
    end else begin
      color_q <= color_d;
      dwell_q <= dwell_d;
      step_q  <= step;
      sw_q    <= sw;
    end
  end

  // Next colour and dwell count; a mode change only clears the dwell timer.
  always_comb begin
    color_d = color_q;
    dwell_d = dwell_q;
    advance = 1'b0;
    if (sw_chg) begin
      dwell_d = '0;
    end else begin
      case (mode_eff)
        M_AUTO, M_FADE: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            advance = 1'b1;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        M_MANUAL: begin
          dwell_d = '0;
          advance = step_rise;
        end
        default: ;
      endcase
    end
    if (advance) begin
      if (color_q == C_OFF || color_q == C_PURPLE) color_d = C_RED;
      else                                         color_d = color_t'(color_q + 3'd1);
    end
  end

  // Next duty: frozen in HOLD, ramped in FADE, otherwise tracks the next colour.
  always_comb begin
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    case (mode_eff)
      M_HOLD: ;
`ifdef COLOR_SEQ_FADE_EN
      M_FADE: begin
        if (fade_tc) begin
          r_d = toward(r_q, scale(pal_cur[23:16]));
          g_d = toward(g_q, scale(pal_cur[15:8]));
          b_d = toward(b_q, scale(pal_cur[7:0]));
        end
      end
`endif
      default: begin
        r_d = scale(pal_next[23:16]);
        g_d = scale(pal_next[15:8]);
        b_d = scale(pal_next[7:0]);
      end
    endcase
  end

  // Duty registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  // Free-running PWM counter (period 2^DUTY_W-1) and registered comparators.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      pwm_r   <= 1'b0;
      pwm_g   <= 1'b0;
      pwm_b   <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      pwm_r   <= (pwm_cnt < r_q);
      pwm_g   <= (pwm_cnt < g_q);
      pwm_b   <= (pwm_cnt < b_q);
    end
  end

  assign color_idx = color_q;
  assign r_duty    = r_q;
  assign g_duty    = g_q;
  assign b_duty    = b_q;

endmodule

// File: tb/tb_color_seq_fader.sv
// Scoreboard bench for color_seq_fader: the stimulus pushes the expected
// (cycle, index, duty) for every colour change; a negedge monitor pops and
// compares whenever color_idx changes. PWM and reset values checked directly.
module tb_color_seq_fader;
  localparam int DUTY_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       sw = 2'b00;
  logic             step = 1'b0;
  logic [2:0]       color_idx;
  logic [DUTY_W-1:0] r_duty, g_duty, b_duty;
  logic             pwm_r, pwm_g, pwm_b;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [2:0] idx;
    logic [7:0] r, g, b;
  } exp_t;
  exp_t sb_q[$];
  logic [2:0] prev_idx = 3'd7;

  // Hand-entered palette (DUTY_W=8, so scaling is identity).
  int pal_r[8] = '{255, 255, 255, 0,   0,   8,  160, 0};
  int pal_g[8] = '{0,   97,  255, 255, 0,   46, 32,  0};
  int pal_b[8] = '{0,   0,   0,   0,   255, 84, 240, 0};

  color_seq_fader #(.DUTY_W(8), .DWELL_CYCLES(10), .FADE_DIV(2)) dut (
    .clk(clk), .rst(rst), .sw(sw), .step(step), .color_idx(color_idx),
    .r_duty(r_duty), .g_duty(g_duty), .b_duty(b_duty),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b)
  );

  always #5 clk = ~clk;

  // Cycles since the last reset edge.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int i);
    exp_t e;
    e.cyc = c; e.idx = 3'(i);
    e.r = 8'(pal_r[i]); e.g = 8'(pal_g[i]); e.b = 8'(pal_b[i]);
    sb_q.push_back(e);
  endtask

  task automatic push_raw(input int c, input int i, input int r, input int g, input int b);
    exp_t e;
    e.cyc = c; e.idx = 3'(i); e.r = 8'(r); e.g = 8'(g); e.b = 8'(b);
    sb_q.push_back(e);
  endtask

  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse();
    step = 1'b1; step_clk(1);
    step = 1'b0; step_clk(2);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_idx"}, color_idx, 7);
    chk({tag, "_duty"}, {r_duty, g_duty, b_duty}, 0);
    chk({tag, "_pwm"}, {pwm_r, pwm_g, pwm_b}, 0);
  endtask

  // Two full PWM periods (510 cycles) of high-time counts.
  task automatic pwm_window(input string tag, input int er, input int eg, input int eb);
    int cr, cg, cb;
    cr = 0; cg = 0; cb = 0;
    repeat (510) begin
      @(negedge clk);
      cr += int'(pwm_r); cg += int'(pwm_g); cb += int'(pwm_b);
    end
    chk({tag, "_pwm_r_high"}, cr, er);
    chk({tag, "_pwm_g_high"}, cg, eg);
    chk({tag, "_pwm_b_high"}, cb, eb);
    @(posedge clk); #2;
  endtask

  // Monitor: every colour change must match the next scoreboard entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      prev_idx = color_idx;
    end else if (color_idx !== prev_idx) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_idx_change", color_idx, prev_idx);
      end else begin
        e = sb_q.pop_front();
        chk("ev_idx", color_idx, e.idx);
        chk("ev_r_duty", r_duty, e.r);
        chk("ev_g_duty", g_duty, e.g);
        chk("ev_b_duty", b_duty, e.b);
        if (e.cyc >= 0) chk("ev_cycle", cyc, e.cyc);
      end
      prev_idx = color_idx;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step_clk(3);
    check_reset_vals("reset");
    rst = 1'b0;

    // AUTO: OFF,0..6,0 every 10 cycles.
    for (int i = 0; i < 8; i++) push((i + 1) * 10, i % 7);
    step_clk(80);

    // MANUAL: three pulses plus one long press advance by exactly 4.
    sw = 2'b11; step_clk(2);
    for (int i = 1; i <= 4; i++) push(-1, i);
    pulse(); pulse(); pulse();
    step = 1'b1; step_clk(5); step = 1'b0; step_clk(2);
    step_clk(12);
    chk("manual_idx", color_idx, 4);
    chk("manual_b_duty", b_duty, 255);

    // MANUAL wrap from 4 to 2.
    push(-1, 5); push(-1, 6); push(-1, 0); push(-1, 1); push(-1, 2);
    repeat (5) pulse();

    // HOLD at idx 2, step ignored.
    sw = 2'b01; step_clk(20);
    pulse();
    step_clk(28);
    chk("hold_idx", color_idx, 2);
    chk("hold_duty", {r_duty, g_duty, b_duty}, {8'd255, 8'd255, 8'd0});
    pwm_window("idx2", 510, 510, 0);

    sw = 2'b11; step_clk(2);
    push(-1, 3); push(-1, 4); push(-1, 5);
    repeat (3) pulse();
    sw = 2'b01; step_clk(3);
    pwm_window("idx5", 16, 92, 168);

    sw = 2'b11; step_clk(2);
    push(-1, 6); push(-1, 0); push(-1, 1);
    repeat (3) pulse();
    sw = 2'b01; step_clk(3);
    chk("idx1_g_duty", g_duty, 97);
    pwm_window("idx1", 510, 194, 0);

    // Reset, then sw=10 from OFF.
    push_raw(-1, 7, 0, 0, 0);
    rst = 1'b1; sw = 2'b10; step_clk(1);
    rst = 1'b0;
    check_reset_vals("reset_hold");
`ifdef COLOR_SEQ_FADE_EN
    push_raw(10, 0, 0, 0, 0);
    push_raw(20, 1, 5, 0, 0);
    push_raw(30, 2, 10, 5, 0);
    push_raw(40, 3, 15, 10, 0);
    push_raw(50, 4, 10, 15, 0);
    step_clk(15);
    chk("fade_r_ramp", r_duty, 2);
    chk("fade_b_zero", b_duty, 0);
    step_clk(38);
`else
    for (int i = 0; i < 5; i++) push((i + 1) * 10, i);
    step_clk(53);
`endif

    // Reset mid-dwell at idx 4 restarts from OFF.
    push_raw(-1, 7, 0, 0, 0);
    rst = 1'b1; step_clk(1);
    rst = 1'b0;
    check_reset_vals("reset_mid");
`ifdef COLOR_SEQ_FADE_EN
    push_raw(10, 0, 0, 0, 0);
    push_raw(20, 1, 5, 0, 0);
`else
    push(10, 0);
    push(20, 1);
`endif
    step_clk(24);

    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
